// File: rtl/clken_sequencer_if.sv
// Configuration and status bundle of the clock-enable sequencer.
// The design side uses the slave modport; the controller or bench uses master.
interface clken_sequencer_if #(
  parameter int NCH   = 2,
  parameter int DIV_W = 8
);
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             sync_i;
  logic [NCH-1:0]   ce;
  logic             rst_out_n;
  logic             ready;
  logic [7:0]       lock_lost_cnt;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_phase, sync_i,
    input  ce, rst_out_n, ready, lock_lost_cnt
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_phase, sync_i,
    output ce, rst_out_n, ready, lock_lost_cnt
  );
endinterface

// File: rtl/clken_sequencer.sv
// Qualifies PLL lock, sequences a downstream reset and generates NCH
// runtime-programmable clock-enable strobes from the single fast clock.
module clken_sequencer #(
  parameter int NCH         = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_WAIT   = 1024,
  parameter int DEFAULT_DIV = 3
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              pll_locked,
  clken_sequencer_if.slave  bus
);
  localparam int WCW = (LOCK_WAIT > 2) ? $clog2(LOCK_WAIT) : 1;

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, lk_q;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             ready_q, rst_n_q;
  logic [7:0]       lost_q;
  logic             in_run, stay_run, realign;
  logic [NCH-1:0]   ce;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lk_q    <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    case (state_q)
      WAIT_LOCK: if (lk_q) state_d = STABLE;
      STABLE: begin
        if (!lk_q)                              state_d = WAIT_LOCK;
        else if (wcnt_q == WCW'(LOCK_WAIT - 1)) state_d = RUN;
        else                                    wcnt_d  = wcnt_q + 1'b1;
      end
      RUN:     if (!lk_q) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign in_run   = (state_q == RUN);
  assign stay_run = in_run && (state_d == RUN);
  // Any cycle not continuing RUN idles the counters and applies pending config.
  assign realign  = !stay_run || bus.sync_i;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT_LOCK;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      rst_n_q <= 1'b0;
      lost_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ready_q <= (state_d == RUN);
      rst_n_q <= (state_d == RUN);
      if (in_run && (state_d != RUN) && (lost_q != 8'hFF))
        lost_q <= lost_q + 8'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DIV_W-1:0] cnt_q, div_q, phase_q, pdiv_q, pphase_q;
      logic [DIV_W-1:0] ndiv, nphase, eff_phase;
      logic             sel, wrap;

      // Indices at or above NCH never match any channel, so they are dropped.
      assign sel       = bus.cfg_we && (bus.cfg_ch == 3'(gi));
      assign ndiv      = sel ? bus.cfg_div   : pdiv_q;
      assign nphase    = sel ? bus.cfg_phase : pphase_q;
      assign wrap      = (cnt_q == div_q);
      assign eff_phase = (phase_q > div_q) ? div_q : phase_q;
      assign ce[gi]    = in_run && (cnt_q == eff_phase);

      always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
          cnt_q    <= '0;
          div_q    <= DIV_W'(DEFAULT_DIV);
          phase_q  <= '0;
          pdiv_q   <= DIV_W'(DEFAULT_DIV);
          pphase_q <= '0;
        end else begin
          pdiv_q   <= ndiv;
          pphase_q <= nphase;
          if (realign || wrap) begin
            cnt_q   <= '0;
            div_q   <= ndiv;
            phase_q <= nphase;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign bus.ce            = ce;
  assign bus.ready         = ready_q;
  assign bus.rst_out_n     = rst_n_q;
  assign bus.lock_lost_cnt = lost_q;
endmodule

// File: tb/tb_clken_sequencer.sv
// Directed bench for clken_sequencer: lock qualification, glitch, retune,
// edge configurations, realignment, lock-loss saturation and async reset.
module tb_clken_sequencer;
  localparam int NCH = 2, DIV_W = 8, LOCK_WAIT = 16, DEFAULT_DIV = 3;

  logic clkin = 1'b0, rstn = 1'b0, pll_locked = 1'b0;
  int   n_tests = 0, n_fail = 0, cyc = 0, nw = 0;

  clken_sequencer_if #(.NCH(NCH), .DIV_W(DIV_W)) bus();

  clken_sequencer #(.NCH(NCH), .DIV_W(DIV_W), .LOCK_WAIT(LOCK_WAIT),
                    .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clkin(clkin), .rstn(rstn), .pll_locked(pll_locked), .bus(bus.slave)
  );

  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin); #1; cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] ch, input logic [7:0] dv, input logic [7:0] ph);
    bus.cfg_we = 1'b1; bus.cfg_ch = ch; bus.cfg_div = dv; bus.cfg_phase = ph;
    tick();
    bus.cfg_we = 1'b0;
    $display("[TB] cfg ch=%0d div=%0d phase=%0d at cyc %0d", ch, dv, ph, cyc);
  endtask

  task automatic wait_ready(input logic lvl, input int maxc, output int n);
    n = 0;
    while (bus.ready !== lvl && n < maxc) begin
      tick(); n++;
    end
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_phase = '0; bus.sync_i = 1'b0;
    repeat (3) tick();
    check("rst_rstn", bus.rst_out_n, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_ce", bus.ce, 0);
    check("rst_lost", bus.lock_lost_cnt, 0);

    // Lock qualification: run on cycle 18, ce[0] every 4 cycles from there
    rstn = 1'b1; pll_locked = 1'b1;
    for (int n = 0; n <= 30; n++) begin
      tick();
      check("qual_rstn", bus.rst_out_n, (n >= 18));
      check("qual_ce0", bus.ce[0], (n >= 18) && ((n - 18) % 4 == 0));
    end
    $display("[TB] lock qualification done at cyc %0d", cyc);

    // One-cycle lock glitch during STABLE restarts the qualification
    rstn = 1'b0; pll_locked = 1'b0; tick(); tick();
    rstn = 1'b1; tick(); tick();
    pll_locked = 1'b1; repeat (8) tick();
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1;
    repeat (18) tick();
    check("glitch_wait", bus.ready, 0);
    tick();
    check("glitch_run", bus.ready, 1);
    check("glitch_lost", bus.lock_lost_cnt, 0);
    check("run_ce1_first", bus.ce[1], 1);
    $display("[TB] glitch recovery done at cyc %0d", cyc);

    // Retune ch1 mid-period: old period finishes, then ce at cnt 2 every 8
    tick();
    cfg(3'd1, 8'd7, 8'd2);
    for (int k = 2; k <= 24; k++) begin
      if (k > 2) tick();
      check("retune_ce1", bus.ce[1], (k == 6) || (k == 14) || (k == 22));
      check("retune_ce0", bus.ce[0], (k % 4 == 0));
    end
    cfg(3'd1, 8'd7, 8'd9);
    for (int k = 25; k <= 44; k++) begin
      if (k > 25) tick();
      check("clamp_ce1", bus.ce[1], (k == 35) || (k == 43));
    end

    // div 0 applied through sync: ce[0] constantly high
    bus.sync_i = 1'b1;
    cfg(3'd0, 8'd0, 8'd0);
    bus.sync_i = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) tick();
      check("div0_ce0", bus.ce[0], 1);
      check("div0_ce1", bus.ce[1], (j == 7));
    end

    // Out-of-range channel write must not touch any channel
    cfg(3'd5, 8'd1, 8'd0);
    bus.sync_i = 1'b1; tick(); bus.sync_i = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) tick();
      check("badch_ce1", bus.ce[1], (j == 7));
      check("badch_ce0", bus.ce[0], 1);
    end

    // Realignment: misaligned div 3 / div 5, then sync
    cfg(3'd0, 8'd3, 8'd0);
    cfg(3'd1, 8'd5, 8'd0);
    repeat (5) tick();
    bus.sync_i = 1'b1; tick(); bus.sync_i = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) tick();
      check("sync_ce0", bus.ce[0], (k % 4 == 0));
      check("sync_ce1", bus.ce[1], (k % 6 == 0));
    end
    $display("[TB] realignment done at cyc %0d", cyc);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick(); tick();
    check("loss_hold", bus.rst_out_n, 1);
    tick();
    check("loss_rstn", bus.rst_out_n, 0);
    check("loss_ready", bus.ready, 0);
    check("loss_ce", bus.ce, 0);
    check("loss_cnt1", bus.lock_lost_cnt, 1);

    for (int i = 0; i < 299; i++) begin
      pll_locked = 1'b1;
      wait_ready(1'b1, 40, nw);
      check("relock", bus.ready, 1);
      pll_locked = 1'b0;
      wait_ready(1'b0, 10, nw);
      check("unlock", bus.ready, 0);
    end
    check("loss_sat", bus.lock_lost_cnt, 255);
    $display("[TB] lock loss saturation done at cyc %0d", cyc);

    // Asynchronous reset mid-operation restores default configuration
    pll_locked = 1'b1;
    wait_ready(1'b1, 40, nw);
    check("pre_rst_run", bus.ready, 1);
    cfg(3'd1, 8'd0, 8'd0);
    #2 rstn = 1'b0;
    #1;
    check("arst_rstn", bus.rst_out_n, 0);
    check("arst_lost", bus.lock_lost_cnt, 0);
    check("arst_ce", bus.ce, 0);
    rstn = 1'b1;
    wait_ready(1'b1, 40, nw);
    check("arst_run", bus.ready, 1);
    check("arst_ce1_0", bus.ce[1], 1);
    tick();
    check("arst_ce1_1", bus.ce[1], 0);
    repeat (3) tick();
    check("arst_ce1_4", bus.ce[1], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clken_sequencer.md
Name: clken_sequencer

Overview:
- Parametrised successor to the board PLL wrappers. Runs on the PLL output clock.
- Gates design start-up on a qualified PLL lock and issues a sequenced reset.
- Derives NCH independent clock-enable strobes, each with its own runtime divide and phase, so the design uses one fast clock instead of extra PLL outputs.
- Tracks lock-loss events and re-sequences the reset automatically after each one.

Parameters:
- NCH, 2, number of clock-enable channels (1..8).
- DIV_W, 8, width of the per-channel divide and phase fields.
- LOCK_WAIT, 1024, number of consecutive synced-lock cycles required before run (>=2).
- DEFAULT_DIV, 3, reset value of every channel divide (period = DIV+1 cycles).

Ports:
- clkin  in  1  fast clock (PLL output).
- rstn  in  1  **asynchronous, active-low reset.**
- pll_locked  in  1  raw PLL lock; asynchronous to clkin.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  3  channel index for the write.
- cfg_div  in  DIV_W  new divide value.
- cfg_phase  in  DIV_W  new phase value.
- sync_i  in  1  realign all channel counters.
- ce  out  NCH  per-channel one-cycle enable strobes.
- rst_out_n  out  1  sequenced active-low reset for the downstream design.
- ready  out  1  high while in RUN.
- lock_lost_cnt  out  8  saturating count of lock losses seen in RUN.

Behaviour:
- **Reset values** (rstn low, asynchronous): state=WAIT_LOCK, ce=0, rst_out_n=0, ready=0, lock_lost_cnt=0, sync flops=0, wait counter=0, all channel counters=0, div=DEFAULT_DIV, phase=0, pending regs = active values.
- **Lock synchroniser:** pll_locked passes through a 2-FF synchroniser; lk denotes the synchronised value. Latency is 2 cycles.
- **FSM:**
  - WAIT_LOCK: wait counter=0. If lk=1, go to STABLE.
  - STABLE: increment wait counter while lk=1. If lk=0, go to WAIT_LOCK (counter cleared). When the counter reaches LOCK_WAIT-1 with lk=1, go to RUN.
  - RUN: ready=1 and rst_out_n=1, both registered and asserted on the first RUN cycle. If lk=0, go to WAIT_LOCK; the next cycle drives rst_out_n=0, ready=0, ce=0, clears all counters, and increments lock_lost_cnt (saturating at 255).
- **Outside RUN:** ce=0 and channel counters are held at 0.
- **Channel i in RUN:**
  - Counter cnt[i] counts 0..div[i], then wraps to 0.
  - ce[i]=1 combinationally when cnt[i]==min(phase[i], div[i]). A phase greater than div is clamped to div.
  - div=0 gives ce[i] high on every RUN cycle.
- **First RUN cycle:** all counters are 0, so any channel with phase 0 strobes on the first RUN cycle.
- **Configuration:**
  - cfg_we=1 with cfg_ch<NCH loads pending div/phase for that channel. cfg_ch>=NCH is ignored.
  - Pending values become active on the cycle the channel wraps (cnt==div, transitioning to 0). This gives no truncated or stretched period. A later write before the wrap overwrites the earlier pending value.
  - Outside RUN, writes take effect immediately, since the counters are idle.
  - Writes are accepted in every state.
- **sync_i** (RUN only):
  - All counters are forced to 0 on the next cycle, and all pending config is applied at the same time.
  - ce is still evaluated on the current cycle's counts.
  - If sync_i and a wrap occur in the same cycle, sync wins (the result is identical anyway).
  - If sync_i and cfg_we occur in the same cycle, the new write is applied along with the sync.
- **Mid-operation events:**
  - rstn assertion mid-operation restores all reset values immediately, including config.
  - Lock loss keeps config but drops the reset.
- **Widths:** counters are DIV_W bits. lock_lost_cnt never wraps.

Test Plan:
- **Lock qualification:** rstn released, pll_locked=1 at cycle 0 with LOCK_WAIT=16 → rst_out_n=0 until cycle 2+16, then rst_out_n=1 and ready=1; ce[0] (div 3, phase 0) pulses on cycles 18, 22, 26.
- **Lock glitch:** pll_locked dropped for 1 cycle midway through STABLE → wait counter restarts; RUN entered 16 lk-high cycles after recovery; lock_lost_cnt stays 0.
- **Lock loss in RUN:** pll_locked=0 → within 3 cycles rst_out_n=0, ce=0, lock_lost_cnt=1. Repeated 300 times, lock_lost_cnt saturates at 255.
- **Glitch-free retune:** ch1 div=3, write div=7, phase=2 mid-period → remaining old period completes at 4 cycles; then ce[1] pulses every 8 cycles at cnt==2. phase=9 with div=7 behaves as phase 7.
- **Edge configurations:** div=0 → ce constant 1 in RUN. cfg_ch=5 with NCH=2 → no change.
- **Realignment:** ch0 div=3 and ch1 div=5 with counters misaligned, sync_i pulse → both counters 0 the next cycle; with phase 0 both ce strobe together, and coincide again every 12 cycles.
